// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//
// Frames a four-byte ASCII command ("ddd" + op letter) received from a UART
// byte receiver and presents it as a binary operand plus op code on a
// valid/ready handshake. Malformed bytes, bytes arriving while a frame is
// still waiting, and stalls between bytes inside a frame are reported on a
// one-cycle error pulse with a sticky error code.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   rx_data      received byte, meaningful only while rx_valid=1
//   rx_valid     one-cycle strobe per received byte
//   cmd_operand  binary operand 0..999
//   cmd_op       0=sin, 1=cos, 2=sqrt, 3=prime
//   cmd_valid    frame available
//   cmd_ready    consumer accepts the frame
//   frame_err    one-cycle pulse per error
//   err_code     0=overrun, 1=bad digit, 2=bad op, 3=timeout (held until next error)
//   busy         high whenever a frame is in progress or waiting
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned CNT_W          = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [9:0]  cmd_operand,
  output logic [1:0]  cmd_op,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  typedef enum logic [2:0] {
    StD0,
    StD1,
    StD2,
    StOp,
    StHold
  } state_e;

  localparam logic [7:0] ChCr  = 8'h0D;
  localparam logic [7:0] ChLf  = 8'h0A;
  localparam logic [7:0] ChEsc = 8'h1B;

  localparam logic [1:0] ErrOverrun  = 2'd0;
  localparam logic [1:0] ErrBadDigit = 2'd1;
  localparam logic [1:0] ErrBadOp    = 2'd2;
  localparam logic [1:0] ErrTimeout  = 2'd3;

  state_e           state_q, state_d;
  logic [9:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       operand_q, operand_d;
  logic [1:0]       op_q, op_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic       is_digit;
  logic [9:0] digit_val;
  logic       counting;
  logic       expire;

  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  // Lower nibble of '0'..'9' is the digit value.
  assign digit_val = {6'b0, rx_data[3:0]};
  assign counting  = (state_q == StD1) || (state_q == StD2) || (state_q == StOp);
  // The pulse is registered, so fire on the cycle the counter would step onto
  // TIMEOUT_CYCLES-1; a byte in that same cycle wins over the timeout.
  assign expire    = counting && !rx_valid &&
                     ((32'(cnt_q) + 32'd1) >= (TIMEOUT_CYCLES - 32'd1));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    operand_d   = operand_q;
    op_d        = op_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    cnt_d       = (counting && !rx_valid && !expire) ? cnt_q + 1'b1 : '0;

    unique case (state_q)
      StD0: begin
        if (rx_valid) begin
          if (is_digit) begin
            acc_d   = digit_val;
            state_d = StD1;
          end else if (!(rx_data == ChCr || rx_data == ChLf || rx_data == ChEsc)) begin
            frame_err_d = 1'b1;
            err_code_d  = ErrBadDigit;
          end
        end
      end

      StD1, StD2: begin
        if (rx_valid) begin
          if (is_digit) begin
            acc_d   = acc_q * 10'd10 + digit_val;
            state_d = (state_q == StD1) ? StD2 : StOp;
          end else begin
            if (rx_data != ChEsc) begin
              frame_err_d = 1'b1;
              err_code_d  = ErrBadDigit;
            end
            acc_d   = '0;
            state_d = StD0;
          end
        end else if (expire) begin
          frame_err_d = 1'b1;
          err_code_d  = ErrTimeout;
          acc_d       = '0;
          state_d     = StD0;
        end
      end

      StOp: begin
        if (rx_valid) begin
          state_d = StHold;
          case (rx_data)
            8'h73:   op_d = 2'd0;
            8'h63:   op_d = 2'd1;
            8'h72:   op_d = 2'd2;
            8'h61:   op_d = 2'd3;
            default: begin
              op_d    = op_q;
              state_d = StD0;
            end
          endcase
          if (state_d == StHold) begin
            operand_d = acc_q;
          end else begin
            if (rx_data != ChEsc) begin
              frame_err_d = 1'b1;
              err_code_d  = ErrBadOp;
            end
            acc_d = '0;
          end
        end else if (expire) begin
          frame_err_d = 1'b1;
          err_code_d  = ErrTimeout;
          acc_d       = '0;
          state_d     = StD0;
        end
      end

      StHold: begin
        // Bytes are dropped while a frame is outstanding, even on the
        // handshake cycle itself.
        if (rx_valid) begin
          frame_err_d = 1'b1;
          err_code_d  = ErrOverrun;
        end
        if (cmd_ready) begin
          acc_d   = '0;
          state_d = StD0;
        end
      end

      default: begin
        acc_d   = '0;
        state_d = StD0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StD0;
      acc_q       <= '0;
      cnt_q       <= '0;
      operand_q   <= '0;
      op_q        <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      operand_q   <= operand_d;
      op_q        <= op_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_operand = operand_q;
  assign cmd_op      = op_q;
  assign cmd_valid   = (state_q == StHold);
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != StD0);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: table of command strings with expected frames
// and errors, pushed to scoreboard queues and checked by a monitor, plus
// hand-written sequences for hold, overrun, timeout and reset.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [9:0] cmd_operand;
  logic [1:0] cmd_op;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(50),
    .CNT_W         (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_operand(cmd_operand),
    .cmd_op     (cmd_op),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int operand;
    int op;
  } frame_t;

  typedef struct {
    logic [63:0] bytes;  // first byte in [63:56]
    int          n;
    bit          frame;
    int          operand;
    int          op;
    bit          err;
    int          code;
  } vec_t;

  frame_t frame_q[$];
  int     err_q[$];
  int     total = 0;
  int     bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_now(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    drive_now(b);
  endtask

  task automatic push_frame(input int operand, input int op);
    frame_t f;
    f.operand = operand;
    f.op      = op;
    frame_q.push_back(f);
  endtask

  // Scoreboard monitor: samples mid-cycle, after drivers have settled.
  initial begin
    frame_t f;
    int     e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && cmd_valid && cmd_ready) begin
        if (frame_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          f = frame_q.pop_front();
          chk("frame_operand", int'(cmd_operand), f.operand);
          chk("frame_op", int'(cmd_op), f.op);
        end
      end
      if (!reset && frame_err) begin
        if (err_q.size() == 0) begin
          chk("unexpected_err", int'(err_code), -1);
        end else begin
          e = err_q.pop_front();
          chk("err_code", int'(err_code), e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{64'h3132_3373_0000_0000, 4, 1'b1, 123, 0, 1'b0, 0};
    vecs[1]  = '{64'h3478_0000_0000_0000, 2, 1'b0, 0, 0, 1'b1, 1};
    vecs[2]  = '{64'h3030_3772_0000_0000, 4, 1'b1, 7, 2, 1'b0, 0};
    vecs[3]  = '{64'h3031_3271_0000_0000, 4, 1'b0, 0, 0, 1'b1, 2};
    vecs[4]  = '{64'h0D0A_3030_3063_0000, 6, 1'b1, 0, 1, 1'b0, 0};
    vecs[5]  = '{64'h3939_3961_0000_0000, 4, 1'b1, 999, 3, 1'b0, 0};
    vecs[6]  = '{64'h351B_0000_0000_0000, 2, 1'b0, 0, 0, 1'b0, 0};
    vecs[7]  = '{64'h1B00_0000_0000_0000, 1, 1'b0, 0, 0, 1'b0, 0};
    vecs[8]  = '{64'h3132_0D00_0000_0000, 3, 1'b0, 0, 0, 1'b1, 1};
    vecs[9]  = '{64'h3435_3653_0000_0000, 4, 1'b0, 0, 0, 1'b1, 2};
    vecs[10] = '{64'h3A00_0000_0000_0000, 1, 1'b0, 0, 0, 1'b1, 1};
    vecs[11] = '{64'h2F00_0000_0000_0000, 1, 1'b0, 0, 0, 1'b1, 1};
    vecs[12] = '{64'h3836_1B32_3530_6300, 7, 1'b1, 250, 1, 1'b0, 0};
    vecs[13] = '{64'h3330_311B_0000_0000, 4, 1'b0, 0, 0, 1'b0, 0};
    vecs[14] = '{64'h3130_3041_0000_0000, 4, 1'b0, 0, 0, 1'b1, 2};

    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_code", int'(err_code), 0);
    chk("rst_operand", int'(cmd_operand), 0);
    reset = 1'b0;

    // Table-driven commands, consumer always ready.
    cmd_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].frame) push_frame(vecs[i].operand, vecs[i].op);
      if (vecs[i].err) err_q.push_back(vecs[i].code);
      for (int j = 0; j < vecs[i].n; j++) begin
        logic [7:0] b;
        b = vecs[i].bytes[63-8*j -: 8];
        send(b);
      end
      repeat (4) @(negedge clk);
      chk($sformatf("vec%0d_idle", i), int'(busy), 0);
    end

    // Frame held while the consumer stalls for 20 cycles.
    cmd_ready = 1'b0;
    push_frame(999, 3);
    send(8'h39); send(8'h39); send(8'h39); send(8'h61);
    for (int i = 0; i < 20; i++) begin
      chk("hold_valid", int'(cmd_valid), 1);
      chk("hold_operand", int'(cmd_operand), 999);
      chk("hold_op", int'(cmd_op), 3);
      @(negedge clk);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", int'(cmd_valid), 0);
    chk("post_hs_busy", int'(busy), 0);
    chk("post_hs_operand", int'(cmd_operand), 999);

    // Overrun while holding: byte dropped, frame unchanged.
    cmd_ready = 1'b0;
    push_frame(321, 0);
    send(8'h33); send(8'h32); send(8'h31); send(8'h73);
    err_q.push_back(0);
    send(8'h35);
    chk("ovr_pulse", int'(frame_err), 1);
    chk("ovr_valid", int'(cmd_valid), 1);
    chk("ovr_operand", int'(cmd_operand), 321);
    chk("ovr_op", int'(cmd_op), 0);
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("ovr_release", int'(cmd_valid), 0);

    // Overrun on the handshake cycle: both happen.
    cmd_ready = 1'b0;
    push_frame(654, 1);
    send(8'h36); send(8'h35); send(8'h34); send(8'h63);
    err_q.push_back(0);
    @(negedge clk);
    cmd_ready = 1'b1;
    drive_now(8'h37);
    chk("ovr_hs_pulse", int'(frame_err), 1);
    chk("ovr_hs_valid", int'(cmd_valid), 0);
    chk("ovr_hs_busy", int'(busy), 0);

    // Timeout: pulse on the 50th edge counting the edge that took '2'.
    repeat (3) @(negedge clk);
    send(8'h31);
    err_q.push_back(3);
    send(8'h32);
    for (int i = 1; i <= 49; i++) begin
      @(negedge clk);
      if (i < 49) begin
        if (frame_err) chk($sformatf("to_early_%0d", i), 1, 0);
      end else begin
        chk("to_pulse", int'(frame_err), 1);
        chk("to_code", int'(err_code), 3);
        chk("to_busy", int'(busy), 0);
      end
    end
    @(negedge clk);
    chk("to_pulse_width", int'(frame_err), 0);

    // Byte on the expiry cycle is taken instead of timing out.
    push_frame(123, 0);
    send(8'h31);
    send(8'h32);
    repeat (48) @(negedge clk);
    drive_now(8'h33);
    chk("to_edge_noerr", int'(frame_err), 0);
    chk("to_edge_busy", int'(busy), 1);
    send(8'h73);
    repeat (3) @(negedge clk);
    chk("to_edge_done", int'(busy), 0);

    // Reset mid-frame, with a byte in the same cycle.
    send(8'h33);
    send(8'h34);
    @(negedge clk);
    reset    = 1'b1;
    rx_data  = 8'h35;
    rx_valid = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_operand", int'(cmd_operand), 0);
    chk("mid_rst_op", int'(cmd_op), 0);
    chk("mid_rst_valid", int'(cmd_valid), 0);
    chk("mid_rst_err", int'(frame_err), 0);
    chk("mid_rst_code", int'(err_code), 0);
    push_frame(100, 0);
    send(8'h31); send(8'h30); send(8'h30); send(8'h73);
    repeat (5) @(negedge clk);
    chk("final_operand", int'(cmd_operand), 100);

    chk("frames_left", frame_q.size(), 0);
    chk("errs_left", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits between the UART byte receiver and the calculator's function units (sine, cosine, square root, prime).
- Assembles a four-byte ASCII command into a validated frame: three decimal digits followed by one operation letter.
- Presents the result as a binary operand plus an op code on a valid/ready handshake.
- Replaces ad-hoc digit capture with explicit framing, error reporting and an inter-byte timeout.

Parameters:
- TIMEOUT_CYCLES, 100000000, cycles allowed between bytes inside a frame before abort (1 s at 100 MHz).
- CNT_W, 27, width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte; meaningful only while rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- cmd_operand  out  10  binary operand, 0..999
- cmd_op  out  2  0=sin, 1=cos, 2=sqrt, 3=prime
- cmd_valid  out  1  frame available
- cmd_ready  in  1  consumer accepts the frame
- frame_err  out  1  one-cycle pulse on any error
- err_code  out  2  0=overrun, 1=bad digit, 2=bad op, 3=timeout; holds until the next error
- busy  out  1  high in any state other than D0

Behaviour:

Reset:
- Clock: clk. Reset: reset, synchronous, active-high.
- Reset dominates every other input in the same cycle.
- On reset: state=D0, accumulator=0, timeout counter=0, cmd_operand=0, cmd_op=0, cmd_valid=0, frame_err=0, err_code=0, busy=0.

States:
- D0: waiting for the hundreds digit.
- D1: waiting for the tens digit.
- D2: waiting for the ones digit.
- OP: waiting for the op letter.
- HOLD: frame presented, waiting for cmd_ready.

Digits:
- A digit is 0x30..0x39; its value is rx_data-0x30.
- On a valid digit: acc <= acc*10 + value, using 10-bit arithmetic (max 999, no overflow possible).
- In D0, acc is loaded with the value directly.
- Transitions: D0->D1->D2->OP.

Whitespace:
- CR (0x0D) and LF (0x0A) are silently ignored in D0 only.

Escape:
- ESC (0x1B) in D1, D2 or OP returns to D0 with no error and clears acc.
- In D0, ESC is ignored.

Bad digit:
- Any other byte in D0/D1/D2 pulses frame_err with err_code=1, then goes to D0.

Op letter:
- In OP: 's'(0x73)->0, 'c'(0x63)->1, 'r'(0x72)->2, 'a'(0x61)->3. Lowercase only.
- On a valid letter: cmd_operand<=acc, cmd_op<=code, cmd_valid<=1, state HOLD.
- cmd_valid rises the cycle after the rx_valid cycle that carried the letter.
- Any other byte in OP pulses frame_err with err_code=2, then goes to D0.

Handshake:
- In HOLD, cmd_valid stays 1 and cmd_operand/cmd_op stay stable until a cycle with cmd_valid & cmd_ready.
- The next cycle after that handshake: cmd_valid=0, state D0, acc=0.
- cmd_operand/cmd_op keep their last values after the handshake.
- cmd_ready is ignored while cmd_valid=0.

Overrun:
- Any rx_valid while in HOLD (including the handshake cycle) drops the byte and pulses frame_err with err_code=0.
- Remain in HOLD unless the handshake completes in that same cycle.

Timeout:
- The counter runs in D1, D2 and OP only.
- It clears on every accepted byte and on entry to D0/HOLD.
- When it reaches TIMEOUT_CYCLES-1 with no rx_valid: pulse frame_err with err_code=3, go to D0, clear acc.
- If rx_valid arrives in the same cycle as expiry, the byte is processed normally and no timeout occurs.

Error outputs:
- frame_err is registered, high exactly one cycle per error.
- err_code updates in the same cycle that frame_err rises.

Test Plan:
- Send "123s" with cmd_ready=1 -> cmd_valid high for 1 cycle with cmd_operand=123, cmd_op=0; frame_err never pulses.
- Send "999a" with cmd_ready=0 for 20 cycles, then 1 -> cmd_valid held 21 cycles, operand=999, op=3 stable; drops to 0 the cycle after the handshake.
- Send "4x" -> frame_err pulse with err_code=1, busy=0; then "007r" -> operand=7, op=2.
- Send "012q" -> err_code=2; then CR, LF, "000c" -> operand=0, op=1 with no extra error.
- TIMEOUT_CYCLES=50: send "12" then idle -> frame_err with err_code=3 exactly 50 cycles after the '2' strobe. Repeat with a byte arriving on the expiry cycle -> no timeout.
- Overrun and reset: during HOLD send '5' -> err_code=0, frame unchanged. Assert reset mid-frame after "34" -> all outputs 0; then "100s" -> operand=100.
